// File: rtl/asic_freq.sv
// asic_freq: frequency-counter peripheral for one harness project slot.
//
// Counts rising edges of an asynchronous test signal over a programmable
// window of system clocks, keeps a free-running edge count, streams each
// windowed result out of a UART pin and drives a 9-digit multiplexed
// 7-segment display.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   addr      register word address (bus byte address bits 5:2)
//   value     write data
//   strobe    write enable, one clock wide, full 32-bit writes only
//   samplee   asynchronous signal under test
//   o         edge count latched at the end of the last window
//   oc        free-running edge count, wraps modulo 2^32
//   tx        UART output, 8N1, idle high
//   col_drvs  one-hot digit select, bit i selects digit i
//   seg_drvs  segments {dp,g,f,e,d,c,b,a}, active-high
//
// Register map (word addresses):
//   0 div     UART clocks per bit, values below 4 are raised to 4
//   1 period  window length in clocks, 0 behaves as 1
//   2 mode    bit 0: 0 = display o, 1 = display the digit registers
//   3 digits  digits 0..7, one nibble each, digit 0 in bits 3:0
//   4 digit8  nibble shown on digit 8 in mode 1
//   5 dps     decimal point per digit, bit i for digit i
module asic_freq #(
  parameter logic [31:0] UART_DIV_RST = 32'd217,
  parameter logic [31:0] PERIOD_RST   = 32'd10000000,
  parameter int          SCAN_BITS    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  addr,
  input  logic [31:0] value,
  input  logic        strobe,
  input  logic        samplee,
  output logic [31:0] o,
  output logic [31:0] oc,
  output logic        tx,
  output logic [8:0]  col_drvs,
  output logic [7:0]  seg_drvs
);

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_t;

  // Configuration registers
  logic [31:0] div;
  logic [31:0] period;
  logic        mode;
  logic [31:0] digits;
  logic [3:0]  digit8;
  logic [8:0]  dps;

  // Input synchronizer and edge detect
  logic sync_meta;
  logic sync_cur;
  logic sync_prev;
  logic edge_hit;

  // Measurement window
  logic [31:0] tick;
  logic [31:0] win_cnt;
  logic [31:0] period_last;
  logic        close_win;
  logic        send_req;

  // UART transmitter
  uart_state_t uart_state;
  uart_state_t uart_state_nxt;
  logic [31:0] bit_timer;
  logic [2:0]  bit_idx;
  logic [1:0]  byte_idx;
  logic [31:0] shift;
  logic [7:0]  cur_byte;
  logic        bit_done;
  logic        tx_nxt;

  // Display scan
  logic [SCAN_BITS-1:0] scan_cnt;
  logic [3:0]           scan_idx;
  logic [4:0]           nib_lsb;
  logic [3:0]           nibble;
  logic                 blank;
  logic [6:0]           seg7;

  // Register file. div is clamped so every UART bit lasts at least four
  // clocks; period is stored as written and the zero case is handled where
  // the window length is derived.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div    <= UART_DIV_RST;
      period <= PERIOD_RST;
      mode   <= 1'b0;
      digits <= 32'd0;
      digit8 <= 4'd0;
      dps    <= 9'd0;
    end else if (strobe) begin
      case (addr)
        4'd0: div    <= (value < 32'd4) ? 32'd4 : value;
        4'd1: period <= value;
        4'd2: mode   <= value[0];
        4'd3: digits <= value;
        4'd4: digit8 <= value[3:0];
        4'd5: dps    <= value[8:0];
        default: ;
      endcase
    end
  end

  // Two-flop synchronizer plus one more flop for edge detection. A rising
  // edge on the pin reaches the counters on the third clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_cur  <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_meta <= samplee;
      sync_cur  <= sync_meta;
      sync_prev <= sync_cur;
    end
  end

  assign edge_hit = sync_cur & ~sync_prev;

  // The >= compare lets a shortened period close an overlong window on the
  // very next clock instead of waiting for tick to wrap.
  assign period_last = (period == 32'd0) ? 32'd0 : (period - 32'd1);
  assign close_win   = (tick >= period_last);

  // Window and free-running counters. The edge seen on the closing cycle
  // belongs to the window being closed. send_req is registered so the UART
  // captures o after it has taken the new result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick     <= 32'd0;
      win_cnt  <= 32'd0;
      o        <= 32'd0;
      oc       <= 32'd0;
      send_req <= 1'b0;
    end else begin
      oc       <= oc + {31'd0, edge_hit};
      send_req <= close_win;
      if (close_win) begin
        o       <= win_cnt + {31'd0, edge_hit};
        win_cnt <= 32'd0;
        tick    <= 32'd0;
      end else begin
        win_cnt <= win_cnt + {31'd0, edge_hit};
        tick    <= tick + 32'd1;
      end
    end
  end

  assign cur_byte = shift[31:24];
  assign bit_done = (bit_timer == 32'd0);

  // UART state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uart_state <= UART_IDLE;
    end else begin
      uart_state <= uart_state_nxt;
    end
  end

  // UART next state and line level. Each state lasts one bit time; the data
  // state repeats for eight bits and the stop state chains into the next
  // start bit until all four bytes have gone out.
  always_comb begin
    uart_state_nxt = uart_state;
    tx_nxt         = 1'b1;
    case (uart_state)
      UART_IDLE: begin
        if (send_req) uart_state_nxt = UART_START;
      end
      UART_START: begin
        tx_nxt = 1'b0;
        if (bit_done) uart_state_nxt = UART_DATA;
      end
      UART_DATA: begin
        tx_nxt = cur_byte[bit_idx];
        if (bit_done && (bit_idx == 3'd7)) uart_state_nxt = UART_STOP;
      end
      UART_STOP: begin
        if (bit_done) begin
          uart_state_nxt = (byte_idx == 2'd3) ? UART_IDLE : UART_START;
        end
      end
      default: uart_state_nxt = UART_IDLE;
    endcase
  end

  // UART datapath. The bit timer is reloaded from div at every bit start so
  // a divider write lands on the next bit boundary. The line is driven from
  // a flop so the pin never glitches on state decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx        <= 1'b1;
      bit_timer <= 32'd0;
      bit_idx   <= 3'd0;
      byte_idx  <= 2'd0;
      shift     <= 32'd0;
    end else begin
      tx <= tx_nxt;
      if (uart_state == UART_IDLE) begin
        if (send_req) begin
          shift     <= o;
          byte_idx  <= 2'd0;
          bit_idx   <= 3'd0;
          bit_timer <= div - 32'd1;
        end
      end else if (bit_done) begin
        bit_timer <= div - 32'd1;
        if (uart_state == UART_DATA) begin
          bit_idx <= bit_idx + 3'd1;
        end
        if (uart_state == UART_STOP) begin
          shift    <= {shift[23:0], 8'd0};
          byte_idx <= byte_idx + 2'd1;
        end
      end else begin
        bit_timer <= bit_timer - 32'd1;
      end
    end
  end

  // Display scan: each digit is held for 2^SCAN_BITS clocks, index 0..8.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= 4'd0;
    end else begin
      scan_cnt <= scan_cnt + SCAN_BITS'(1);
      if (&scan_cnt) begin
        scan_idx <= (scan_idx == 4'd8) ? 4'd0 : (scan_idx + 4'd1);
      end
    end
  end

  assign nib_lsb = {scan_idx[2:0], 2'b00};

  // Digit source: in mode 0 digits 0..7 show o and digit 8 is dark; in
  // mode 1 everything comes from the digit registers.
  always_comb begin
    nibble = 4'd0;
    blank  = 1'b0;
    if (scan_idx < 4'd8) begin
      nibble = mode ? digits[nib_lsb +: 4] : o[nib_lsb +: 4];
    end else if (mode) begin
      nibble = digit8;
    end else begin
      blank = 1'b1;
    end
  end

  // Hex to segments {g,f,e,d,c,b,a}.
  always_comb begin
    seg7 = 7'h00;
    case (nibble)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;
      4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;
      4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;
      4'hF: seg7 = 7'h71;
      default: seg7 = 7'h00;
    endcase
  end

  // Drive the selected column and its segments plus decimal point.
  always_comb begin
    col_drvs = 9'd0;
    col_drvs = 9'd1 << scan_idx;
    seg_drvs = {dps[scan_idx], blank ? 7'h00 : seg7};
  end

endmodule

// File: tb/tb_asic_freq.sv
// tb_asic_freq: self-checking bench for asic_freq.
//
// A behavioural model (edge history, window arithmetic, register shadow,
// scan position from elapsed clocks) predicts o, oc, col_drvs and seg_drvs
// every clock; the UART is checked bit by bit against the expected 8N1
// waveform of the latched count.
module tb_asic_freq;

  localparam int          SB   = 2;
  localparam logic [31:0] PRST = 32'd50;
  localparam logic [31:0] DRST = 32'd5;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk;
  logic        rst;
  logic [3:0]  addr;
  logic [31:0] value;
  logic        strobe;
  logic        samplee;
  logic [31:0] o;
  logic [31:0] oc;
  logic        tx;
  logic [8:0]  col_drvs;
  logic [7:0]  seg_drvs;

  int assert_count = 0;
  int fail_count   = 0;
  int pattern      = 0;

  // Model state
  logic [31:0] m_o, m_oc, m_win, m_tick, m_period, m_div, m_digits;
  logic        m_mode;
  logic [3:0]  m_digit8;
  logic [8:0]  m_dps;
  logic        p1, p2, p3;
  int          m_cyc;

  asic_freq #(
    .UART_DIV_RST(DRST),
    .PERIOD_RST  (PRST),
    .SCAN_BITS   (SB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .value   (value),
    .strobe  (strobe),
    .samplee (samplee),
    .o       (o),
    .oc      (oc),
    .tx      (tx),
    .col_drvs(col_drvs),
    .seg_drvs(seg_drvs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    m_o = 0; m_oc = 0; m_win = 0; m_tick = 0;
    m_period = PRST; m_div = DRST;
    m_mode = 1'b0; m_digits = 0; m_digit8 = 0; m_dps = 0;
    p1 = 1'b0; p2 = 1'b0; p3 = 1'b0;
    m_cyc = 0;
  endtask

  function automatic logic [7:0] expSeg();
    int         idx;
    logic [3:0] nib;
    logic [6:0] s;
    idx = (m_cyc >> SB) % 9;
    if (idx < 8) begin
      nib = 4'((m_mode ? m_digits : m_o) >> (4 * idx));
      s   = SEG_TAB[nib];
    end else begin
      s = m_mode ? SEG_TAB[m_digit8] : 7'h00;
    end
    return {m_dps[idx], s};
  endfunction

  task automatic checkOutput();
    int idx;
    idx = (m_cyc >> SB) % 9;
    checkEq("o", o, m_o);
    checkEq("oc", oc, m_oc);
    checkEq("col_drvs", {23'd0, col_drvs}, 32'(1) << idx);
    checkEq("seg_drvs", {24'd0, seg_drvs}, {24'd0, expSeg()});
  endtask

  task automatic applyStimulus();
    case (pattern)
      0: samplee = 1'b0;
      1: samplee = 1'($urandom);
      2: samplee = ((m_cyc % 10) < 5);
      default: samplee = ~samplee;
    endcase
  endtask

  // One clock: advance the model by the rules, then compare.
  task automatic step();
    logic [31:0] e;
    logic [31:0] eff;
    @(posedge clk);
    m_cyc++;
    e  = {31'd0, p2 & ~p3};
    p3 = p2; p2 = p1; p1 = samplee;
    eff = (m_period == 0) ? 32'd1 : m_period;
    if (m_tick >= eff - 32'd1) begin
      m_o = m_win + e; m_win = 0; m_tick = 0;
    end else begin
      m_tick++; m_win = m_win + e;
    end
    m_oc = m_oc + e;
    if (strobe) begin
      case (addr)
        4'd0: m_div    = (value < 4) ? 32'd4 : value;
        4'd1: m_period = value;
        4'd2: m_mode   = value[0];
        4'd3: m_digits = value;
        4'd4: m_digit8 = value[3:0];
        4'd5: m_dps    = value[8:0];
        default: ;
      endcase
    end
    #1;
    checkOutput();
    applyStimulus();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic writeReg(input logic [3:0] a, input logic [31:0] v);
    addr = a; value = v; strobe = 1'b1;
    step();
    strobe = 1'b0;
  endtask

  // Waits (bounded) for a start bit, then checks every clock of the
  // four-byte frame against the latched count, MSB byte first.
  task automatic uartReceive(input string tag);
    logic        found;
    logic [31:0] word;
    logic [7:0]  cur;
    logic        expbit;
    int          d, bitpos;
    found = 1'b0;
    for (int i = 0; i < 1500 && !found; i++) begin
      step();
      if (tx === 1'b0) found = 1'b1;
    end
    checkEq({tag, "_start_seen"}, {31'd0, found}, 32'd1);
    if (found) begin
      word = m_o;
      d    = int'(m_div);
      for (int c = 0; c < 40 * d; c++) begin
        cur    = 8'(word >> (8 * (3 - c / (10 * d))));
        bitpos = (c % (10 * d)) / d;
        if (bitpos == 0)      expbit = 1'b0;
        else if (bitpos == 9) expbit = 1'b1;
        else                  expbit = cur[bitpos - 1];
        checkEq({tag, "_tx_bit"}, {31'd0, tx}, {31'd0, expbit});
        step();
      end
      checkEq({tag, "_tx_idle_after"}, {31'd0, tx}, 32'd1);
    end
  endtask

  initial begin
    logic [31:0] oc_a;
    logic        found;

    rst = 1'b1; addr = 4'd0; value = 32'd0; strobe = 1'b0; samplee = 1'b0;
    resetModel();
    #1;
    $display("[TB] reset state");
    checkEq("rst_o", o, 32'd0);
    checkEq("rst_oc", oc, 32'd0);
    checkEq("rst_tx", {31'd0, tx}, 32'd1);
    checkEq("rst_col", {23'd0, col_drvs}, 32'h001);
    checkEq("rst_seg", {24'd0, seg_drvs}, 32'h3F);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    resetModel();
    run(5);

    $display("[TB] square wave, period 100");
    writeReg(4'd1, 32'd100);
    pattern = 2;
    run(200);
    oc_a = oc;
    run(150);
    checkEq("o_square_window", o, 32'd10);
    checkEq("oc_increasing", {31'd0, (oc > oc_a)}, 32'd1);

    $display("[TB] UART frame at div 4");
    writeReg(4'd1, 32'd100000);
    run(250);
    writeReg(4'd0, 32'd3);
    pattern = 3;
    writeReg(4'd1, 32'd600);
    uartReceive("uart_div4");

    $display("[TB] display mode 1");
    writeReg(4'd2, 32'd1);
    writeReg(4'd3, 32'h76543210);
    writeReg(4'd4, 32'd8);
    writeReg(4'd5, 32'h1FF);
    run(80);
    writeReg(4'd6, 32'hFFFFFFFF);
    writeReg(4'd15, 32'hFFFFFFFF);
    writeReg(4'd3, $urandom);
    writeReg(4'd5, $urandom);
    writeReg(4'd4, $urandom);
    run(40);
    writeReg(4'd2, 32'd0);
    run(40);

    $display("[TB] period 0 and 2");
    pattern = 1;
    writeReg(4'd1, 32'd0);
    run(60);
    writeReg(4'd1, 32'd2);
    run(20);

    $display("[TB] reset during UART frame");
    pattern = 3;
    writeReg(4'd1, 32'd30);
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      step();
      if (tx === 1'b0) found = 1'b1;
    end
    checkEq("pre_reset_tx_low", {31'd0, found}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkEq("mid_rst_tx", {31'd0, tx}, 32'd1);
    checkEq("mid_rst_o", o, 32'd0);
    checkEq("mid_rst_oc", oc, 32'd0);
    checkEq("mid_rst_col", {23'd0, col_drvs}, 32'h001);
    checkEq("mid_rst_seg", {24'd0, seg_drvs}, 32'h3F);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    resetModel();
    pattern = 1;
    uartReceive("uart_defaults");
    run(20);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
